cpu7_csr_intr: RTL and testbench

- Next-generation CSR file for the cpu7 core. Adds to the existing CRMD/PRMD/ERA/EENTRY set:
  - ECFG and ESTAT with an exception code (Ecode).
  - Parametrised SAVE scratch registers.
  - Software, hardware and timer interrupt sources.
  - A constant-timer (TCFG/TVAL/TICLR).
- Exceptions, ertn and interrupt-pending evaluation are resolved at the _e stage.
- The block drives int_pending to ecl, and csr_eentry/csr_era to ifu.

---
 rtl/cpu7_csr_intr_pkg.sv | 31 +++
 rtl/cpu7_csr_timer.sv | 56 +++++
 rtl/cpu7_csr_intr.sv | 143 ++++++++++++++
 tb/tb_cpu7_csr_intr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_csr_intr_pkg.sv
// Shared CSR addresses, field positions and the CRMD/PRMD mode record
// for the cpu7 interrupt-capable CSR file.
package cpu7_csr_intr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [12:0] ECFG_WMASK   = 13'h1BFF;
  localparam int          ESTAT_TI_BIT = 11;
  localparam int          ECODE_LSB    = 16;

  // Same layout for CRMD {IE,PLV} and PRMD {PIE,PPLV}, so ertn is a plain copy.
  typedef struct packed {
    logic       ie;
    logic [1:0] plv;
  } mode_t;

  function automatic logic csr_hit(input logic en, input logic [13:0] addr,
                                   input logic [13:0] target);
    return en && (addr == target);
  endfunction

endpackage

// File: rtl/cpu7_csr_timer.sv
// Constant timer: TCFG holds En/Periodic/InitVal, TVAL counts down,
// TI is a sticky flag cleared by TICLR.
module cpu7_csr_timer
  import cpu7_csr_intr_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_wen,
  input  logic               ticlr_wen,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti
);

  localparam logic [TIMER_W-1:0] TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [TIMER_W-1:0] tcfg_r;
  logic [TIMER_W-1:0] tval_r;
  logic               ti_r;
  logic               fire_s;
  logic [TIMER_W-1:0] reload_s;

  assign fire_s   = tcfg_r[0] && (tval_r == TVAL_ONE);
  assign reload_s = {tcfg_r[TIMER_W-1:2], 2'b00};

  // Config, countdown and sticky TI; a set in the same cycle as TICLR wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_r <= {TIMER_W{1'b0}};
      tval_r <= {TIMER_W{1'b0}};
      ti_r   <= 1'b0;
    end else begin
      if (tcfg_wen) begin
        tcfg_r <= wdata;
        tval_r <= {wdata[TIMER_W-1:2], 2'b00};
      end else if (fire_s) begin
        tval_r <= tcfg_r[1] ? reload_s : {TIMER_W{1'b0}};
      end else if (tcfg_r[0] && (tval_r != {TIMER_W{1'b0}})) begin
        tval_r <= tval_r - TVAL_ONE;
      end
      if (fire_s) begin
        ti_r <= 1'b1;
      end else if (ticlr_wen && wdata[0]) begin
        ti_r <= 1'b0;
      end
    end
  end

  assign tcfg = tcfg_r;
  assign tval = tval_r;
  assign ti   = ti_r;

endmodule

// File: rtl/cpu7_csr_intr.sv
// cpu7 CSR file with exception entry/return, SAVE scratch registers,
// software/hardware/timer interrupt sources and a registered int_pending.
module cpu7_csr_intr
  import cpu7_csr_intr_pkg::*;
#(
  parameter int GRLEN    = 32,
  parameter int NUM_SAVE = 4,
  parameter int NUM_HWI  = 8,
  parameter int TIMER_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [13:0]        csr_raddr,
  output logic [GRLEN-1:0]   csr_rdata,
  input  logic [13:0]        csr_waddr,
  input  logic [GRLEN-1:0]   csr_wdata,
  input  logic               csr_wen,
  input  logic               excp_e,
  input  logic [5:0]         excp_ecode_e,
  input  logic [GRLEN-1:0]   excp_pc_e,
  input  logic               ertn_e,
  input  logic [NUM_HWI-1:0] hw_int,
  output logic               int_pending,
  output logic [GRLEN-1:0]   csr_eentry,
  output logic [GRLEN-1:0]   csr_era
);

  mode_t              crmd_r, prmd_r;
  logic [GRLEN-1:0]   era_r, eentry_r;
  logic [12:0]        lie_r;
  logic [1:0]         swi_r;
  logic [5:0]         ecode_r;
  logic [NUM_HWI-1:0] hwi_meta_r, hwi_sync_r;
  logic [GRLEN-1:0]   save_r [NUM_SAVE];
  logic               int_pending_r;

  logic [12:0]        is_s;
  logic [GRLEN-1:0]   rdata_s, save_rd_s;
  logic [TIMER_W-1:0] tcfg_s, tval_s;
  logic               ti_s;

  cpu7_csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tcfg_wen  (csr_hit(csr_wen, csr_waddr, CSR_TCFG)),
    .ticlr_wen (csr_hit(csr_wen, csr_waddr, CSR_TICLR)),
    .wdata     (csr_wdata[TIMER_W-1:0]),
    .tcfg      (tcfg_s),
    .tval      (tval_s),
    .ti        (ti_s)
  );

  // Exception-sensitive state: excp_e beats ertn_e beats a CSR write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_r  <= 3'b000;
      prmd_r  <= 3'b000;
      era_r   <= {GRLEN{1'b0}};
      ecode_r <= 6'b000000;
    end else if (excp_e) begin
      prmd_r  <= crmd_r;
      crmd_r  <= 3'b000;
      era_r   <= excp_pc_e;
      ecode_r <= excp_ecode_e;
    end else begin
      if (ertn_e) begin
        crmd_r <= prmd_r;
      end else if (csr_hit(csr_wen, csr_waddr, CSR_CRMD)) begin
        crmd_r <= mode_t'(csr_wdata[2:0]);
      end
      if (csr_hit(csr_wen, csr_waddr, CSR_PRMD)) begin
        prmd_r <= mode_t'(csr_wdata[2:0]);
      end
      if (csr_hit(csr_wen, csr_waddr, CSR_ERA)) begin
        era_r <= csr_wdata;
      end
    end
  end

  // Plain CSRs, hw_int synchroniser and the registered interrupt request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eentry_r      <= {GRLEN{1'b0}};
      lie_r         <= 13'b0;
      swi_r         <= 2'b00;
      hwi_meta_r    <= {NUM_HWI{1'b0}};
      hwi_sync_r    <= {NUM_HWI{1'b0}};
      int_pending_r <= 1'b0;
      for (int i = 0; i < NUM_SAVE; i++) save_r[i] <= {GRLEN{1'b0}};
    end else begin
      if (csr_hit(csr_wen, csr_waddr, CSR_EENTRY)) eentry_r <= {csr_wdata[GRLEN-1:6], 6'b000000};
      if (csr_hit(csr_wen, csr_waddr, CSR_ECFG))   lie_r    <= csr_wdata[12:0] & ECFG_WMASK;
      if (csr_hit(csr_wen, csr_waddr, CSR_ESTAT))  swi_r    <= csr_wdata[1:0];
      for (int i = 0; i < NUM_SAVE; i++) begin
        if (csr_hit(csr_wen, csr_waddr, CSR_SAVE0 + 14'(i))) save_r[i] <= csr_wdata;
      end
      hwi_meta_r    <= hw_int;
      hwi_sync_r    <= hwi_meta_r;
      int_pending_r <= crmd_r.ie & (|(is_s & lie_r));
    end
  end

  // ESTAT.IS assembly; unused hardware slots and reserved bits stay 0.
  always_comb begin
    is_s                   = 13'b0;
    is_s[1:0]              = swi_r;
    is_s[NUM_HWI+1:2]      = hwi_sync_r;
    is_s[ESTAT_TI_BIT]     = ti_s;
  end

  // SAVEn read select.
  always_comb begin
    save_rd_s = {GRLEN{1'b0}};
    for (int i = 0; i < NUM_SAVE; i++) begin
      save_rd_s = save_rd_s | ((csr_raddr == CSR_SAVE0 + 14'(i)) ? save_r[i] : {GRLEN{1'b0}});
    end
  end

  // Read mux; unmapped addresses and TICLR return 0.
  always_comb begin
    rdata_s = {GRLEN{1'b0}};
    case (csr_raddr)
      CSR_CRMD:   rdata_s[2:0] = crmd_r;
      CSR_PRMD:   rdata_s[2:0] = prmd_r;
      CSR_ECFG:   rdata_s[12:0] = lie_r;
      CSR_ESTAT: begin
        rdata_s[12:0]            = is_s;
        rdata_s[ECODE_LSB +: 6]  = ecode_r;
      end
      CSR_ERA:    rdata_s = era_r;
      CSR_EENTRY: rdata_s = eentry_r;
      CSR_TCFG:   rdata_s[TIMER_W-1:0] = tcfg_s;
      CSR_TVAL:   rdata_s[TIMER_W-1:0] = tval_s;
      default:    rdata_s = save_rd_s;
    endcase
  end

  assign csr_rdata   = rdata_s;
  assign int_pending = int_pending_r;
  assign csr_eentry  = eentry_r;
  assign csr_era     = era_r;

endmodule

// File: tb/tb_cpu7_csr_intr.sv
// Scoreboard bench for cpu7_csr_intr: directed stimulus pushes expected
// values, an event-driven monitor pops and compares against the DUT.
module tb_cpu7_csr_intr;

  localparam int GRLEN = 32, NUM_SAVE = 4, NUM_HWI = 8, TIMER_W = 32;
  localparam int K_RD = 0, K_PEND = 1, K_ERA = 2, K_EENTRY = 3;

  localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004,
                          A_ESTAT = 14'h005, A_ERA = 14'h006, A_EENTRY = 14'h00C,
                          A_SAVE0 = 14'h030, A_SAVE3 = 14'h033, A_UNMAP = 14'h034,
                          A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;

  logic               clk = 1'b0;
  logic               reset;
  logic [13:0]        csr_raddr, csr_waddr;
  logic [GRLEN-1:0]   csr_rdata, csr_wdata, excp_pc_e, csr_eentry, csr_era;
  logic               csr_wen, excp_e, ertn_e, int_pending;
  logic [5:0]         excp_ecode_e;
  logic [NUM_HWI-1:0] hw_int;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event mon_ev;
  int   checks = 0;
  int   passed = 0;

  always #20 clk = ~clk;

  cpu7_csr_intr #(.GRLEN(GRLEN), .NUM_SAVE(NUM_SAVE), .NUM_HWI(NUM_HWI), .TIMER_W(TIMER_W)) dut (
    .clk(clk), .reset(reset), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .excp_e(excp_e), .excp_ecode_e(excp_ecode_e), .excp_pc_e(excp_pc_e),
    .ertn_e(ertn_e), .hw_int(hw_int), .int_pending(int_pending),
    .csr_eentry(csr_eentry), .csr_era(csr_era)
  );

  always @(mon_ev) begin : monitor
    exp_t        e;
    logic [31:0] act;
    checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_underflow: got empty queue, required an entry");
    end else begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD:    act = csr_rdata;
        K_PEND:  act = {31'b0, int_pending};
        K_ERA:   act = csr_era;
        default: act = csr_eentry;
      endcase
      if (act === e.exp) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.exp);
    end
  end

  task automatic probe(input string name, input int kind, input logic [13:0] addr,
                       input logic [31:0] exp);
    exp_t e;
    csr_raddr = addr;
    e.name = name; e.kind = kind; e.exp = exp;
    sb_q.push_back(e);
    #1;
    -> mon_ev;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
    step(1);
    csr_wen = 1'b0;
  endtask

  task automatic excp(input logic [5:0] code, input logic [31:0] pc);
    excp_e = 1'b1; excp_ecode_e = code; excp_pc_e = pc;
    step(1);
    excp_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; csr_raddr = 14'h0; csr_waddr = 14'h0; csr_wdata = 32'h0; csr_wen = 1'b0;
    excp_e = 1'b0; excp_ecode_e = 6'h0; excp_pc_e = 32'h0; ertn_e = 1'b0; hw_int = 8'h00;
    #1;
    probe("rst_crmd", K_RD, A_CRMD, 32'h0);
    probe("rst_era", K_ERA, A_CRMD, 32'h0);
    probe("rst_eentry", K_EENTRY, A_CRMD, 32'h0);
    probe("rst_pend", K_PEND, A_CRMD, 32'h0);
    step(2);
    reset = 1'b0;
    step(1);

    // plain registers
    wr(A_EENTRY, 32'h1C00_0FFF);
    probe("eentry_rd", K_RD, A_EENTRY, 32'h1C00_0FC0);
    probe("eentry_out", K_EENTRY, A_CRMD, 32'h1C00_0FC0);
    wr(A_SAVE3, 32'hA5A5_0033);
    probe("save3", K_RD, A_SAVE3, 32'hA5A5_0033);
    probe("unmapped", K_RD, A_UNMAP, 32'h0);
    probe("ticlr_rd", K_RD, A_TICLR, 32'h0);

    // exception and return
    wr(A_CRMD, 32'h7);
    probe("crmd_wr", K_RD, A_CRMD, 32'h7);
    excp(6'h09, 32'h1C00_0100);
    probe("excp_crmd", K_RD, A_CRMD, 32'h0);
    probe("excp_prmd", K_RD, A_PRMD, 32'h7);
    probe("excp_era", K_RD, A_ERA, 32'h1C00_0100);
    probe("excp_era_out", K_ERA, A_CRMD, 32'h1C00_0100);
    probe("excp_estat", K_RD, A_ESTAT, 32'h0009_0000);
    ertn_e = 1'b1; step(1); ertn_e = 1'b0;
    probe("ertn_crmd", K_RD, A_CRMD, 32'h7);
    probe("ertn_prmd", K_RD, A_PRMD, 32'h7);

    // collisions with a CSR write
    csr_wen = 1'b1; csr_waddr = A_CRMD; csr_wdata = 32'h3;
    excp(6'h0A, 32'h1C00_0200);
    csr_wen = 1'b0;
    probe("coll_crmd", K_RD, A_CRMD, 32'h0);
    probe("coll_prmd", K_RD, A_PRMD, 32'h7);
    probe("coll_era", K_RD, A_ERA, 32'h1C00_0200);
    csr_wen = 1'b1; csr_waddr = A_SAVE0; csr_wdata = 32'hDEAD_BEEF;
    excp(6'h0B, 32'h1C00_0300);
    csr_wen = 1'b0;
    probe("coll_save0", K_RD, A_SAVE0, 32'hDEAD_BEEF);
    probe("coll2_prmd", K_RD, A_PRMD, 32'h0);
    probe("coll2_estat", K_RD, A_ESTAT, 32'h000B_0000);

    // one-shot timer
    wr(A_TCFG, 32'h9);
    probe("os_tcfg", K_RD, A_TCFG, 32'h9);
    probe("os_tval_load", K_RD, A_TVAL, 32'h8);
    step(7);
    probe("os_tval_1", K_RD, A_TVAL, 32'h1);
    probe("os_ti_pre", K_RD, A_ESTAT, 32'h000B_0000);
    step(1);
    probe("os_ti_set", K_RD, A_ESTAT, 32'h000B_0800);
    probe("os_tval_0", K_RD, A_TVAL, 32'h0);
    wr(A_TICLR, 32'h1);
    step(5);
    probe("os_no_refire", K_RD, A_ESTAT, 32'h000B_0000);
    probe("os_tval_hold", K_RD, A_TVAL, 32'h0);

    // periodic timer
    wr(A_TCFG, 32'h7);
    probe("per_load", K_RD, A_TVAL, 32'h4);
    step(3);
    probe("per_tval_1", K_RD, A_TVAL, 32'h1);
    step(1);
    probe("per_ti1", K_RD, A_ESTAT, 32'h000B_0800);
    probe("per_reload", K_RD, A_TVAL, 32'h4);
    step(2);
    probe("per_tval_2", K_RD, A_TVAL, 32'h2);
    step(1);
    wr(A_TICLR, 32'h1);
    probe("per_set_wins", K_RD, A_ESTAT, 32'h000B_0800);
    probe("per_reload2", K_RD, A_TVAL, 32'h4);
    wr(A_TCFG, 32'h0);
    wr(A_TICLR, 32'h1);
    probe("per_cleared", K_RD, A_ESTAT, 32'h000B_0000);

    // interrupt gating
    wr(A_ECFG, 32'h4);
    hw_int = 8'h01;
    step(3);
    probe("hwi_estat", K_RD, A_ESTAT, 32'h000B_0004);
    probe("pend_ie0", K_PEND, A_CRMD, 32'h0);
    wr(A_CRMD, 32'h4);
    probe("pend_lag", K_PEND, A_CRMD, 32'h0);
    step(1);
    probe("pend_ie1", K_PEND, A_CRMD, 32'h1);
    hw_int = 8'h00;
    step(4);
    probe("pend_hw_low", K_PEND, A_CRMD, 32'h0);
    hw_int = 8'h01;
    step(2);
    probe("pend_sync2", K_PEND, A_CRMD, 32'h0);
    step(1);
    probe("pend_sync3", K_PEND, A_CRMD, 32'h1);
    hw_int = 8'h00;
    wr(A_ECFG, 32'h1FFF);
    probe("ecfg_mask", K_RD, A_ECFG, 32'h1BFF);
    wr(A_ECFG, 32'h3);
    wr(A_ESTAT, 32'h3);
    step(3);
    probe("swi_estat", K_RD, A_ESTAT, 32'h000B_0003);
    probe("swi_pend", K_PEND, A_CRMD, 32'h1);
    wr(A_ESTAT, 32'hFFFF_FFFC);
    step(1);
    probe("estat_ro", K_RD, A_ESTAT, 32'h000B_0000);
    probe("swi_off", K_PEND, A_CRMD, 32'h0);
    wr(A_ESTAT, 32'h3);
    step(1);
    probe("swi_on", K_PEND, A_CRMD, 32'h1);
    excp(6'h15, 32'h1C00_0400);
    probe("excp_pend_lag", K_PEND, A_CRMD, 32'h1);
    probe("excp2_prmd", K_RD, A_PRMD, 32'h4);
    probe("excp2_estat", K_RD, A_ESTAT, 32'h0015_0003);
    step(1);
    probe("excp_pend_off", K_PEND, A_CRMD, 32'h0);
    ertn_e = 1'b1; step(1); ertn_e = 1'b0;
    probe("ertn2_crmd", K_RD, A_CRMD, 32'h4);
    step(1);
    probe("ertn2_pend", K_PEND, A_CRMD, 32'h1);

    // reset mid-count
    wr(A_TCFG, 32'h9);
    step(3);
    probe("mid_tval", K_RD, A_TVAL, 32'h5);
    reset = 1'b1;
    #1;
    probe("arst_tval", K_RD, A_TVAL, 32'h0);
    probe("arst_estat", K_RD, A_ESTAT, 32'h0);
    probe("arst_crmd", K_RD, A_CRMD, 32'h0);
    probe("arst_pend", K_PEND, A_CRMD, 32'h0);
    probe("arst_era", K_ERA, A_CRMD, 32'h0);
    step(1);
    reset = 1'b0;
    step(3);
    probe("post_rst_tval", K_RD, A_TVAL, 32'h0);
    probe("post_rst_save0", K_RD, A_SAVE0, 32'h0);

    #5;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
